// File: rtl/step_countdown.sv
// step_countdown: loadable down-counter that counts a job of N active steps.
// All state changes on the falling edge of clk, in line with the CPU step counter.
//
// Ports:
//   clk        system clock (state updates on negedge)
//   reset      synchronous, active-high; wins over start and hold
//   start      request to load start_val and begin counting
//   start_val  number of active steps in the job (WIDTH bits)
//   hold       freezes the count while running
//   count      remaining steps
//   busy       high while the job is running
//   done       one-cycle completion pulse
module step_countdown #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
    input  logic             hold,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 2) begin : g_width_check
        $error("step_countdown: WIDTH must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    logic             job_zero;
    logic             last_step;

    // A zero-length job goes straight to DONE so it still produces a
    // completion pulse without ever raising busy.
    assign job_zero  = (start_val == CNT_ZERO);

    // The final decrement lands on zero; count==0 in RUN is not reachable
    // through loading, but is treated as a finished job so the counter
    // can never wrap.
    assign last_step = (count_q == CNT_ONE) || (count_q == CNT_ZERO);

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = start_val;
                    state_d = job_zero ? S_DONE : S_RUN;
                end
            end

            S_RUN: begin
                // start is deliberately ignored here: no reload mid-job.
                if (!hold) begin
                    if (last_step) begin
                        count_d = CNT_ZERO;
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
            end

            S_DONE: begin
                // Back-to-back jobs load straight out of DONE.
                if (start) begin
                    count_d = start_val;
                    state_d = job_zero ? S_DONE : S_RUN;
                end else begin
                    count_d = CNT_ZERO;
                    state_d = S_IDLE;
                end
            end

            default: begin
                count_d = CNT_ZERO;
                state_d = S_IDLE;
            end
        endcase
    end

    assign count = count_q;
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_step_countdown.sv
// Scoreboard bench for step_countdown: the driver pushes hand-computed
// expectations, a monitor pops and compares after every falling edge.
module tb_step_countdown;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] start_val;
    logic             hold;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] cnt;
        logic             bsy;
        logic             dn;
        int               id;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   vec_id;
    bit   stim_done;

    step_countdown #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .start_val (start_val),
        .hold      (hold),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs mid-cycle (on posedge, away from the active negedge)
    // and record what the DUT must show after the following negedge.
    task automatic step(input logic r, input logic s,
                        input logic [WIDTH-1:0] sv, input logic h,
                        input logic [WIDTH-1:0] ec, input logic eb,
                        input logic ed);
        exp_t e;
        @(posedge clk);
        reset     = r;
        start     = s;
        start_val = sv;
        hold      = h;
        e.cnt = ec;
        e.bsy = eb;
        e.dn  = ed;
        e.id  = vec_id;
        exp_q.push_back(e);
        vec_id++;
    endtask

    // Monitor: the DUT updates on every negedge, so each edge is one
    // output event to compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (count !== e.cnt || busy !== e.bsy || done !== e.dn) begin
                    errors++;
                    $display("FAIL vec%0d got count=%0d busy=%b done=%b want count=%0d busy=%b done=%b",
                             e.id, count, busy, done, e.cnt, e.bsy, e.dn);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        vec_id    = 0;
        stim_done = 1'b0;
        reset     = 1'b1;
        start     = 1'b0;
        start_val = '0;
        hold      = 1'b0;

        // reset state
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 1, 0, 0, 0);

        // basic count 3,2,1,0
        step(0, 1, 3, 0, 3, 1, 0);
        step(0, 0, 0, 0, 2, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);

        // hold stretches the job by one cycle: 2,1,1,0
        step(0, 1, 2, 0, 2, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        // zero-length job: done, never busy
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        // start while running is ignored
        step(0, 1, 5, 0, 5, 1, 0);
        step(0, 0, 0, 0, 4, 1, 0);
        step(0, 0, 0, 0, 3, 1, 0);
        step(0, 1, 5, 0, 2, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        // back-to-back single-step jobs
        step(0, 1, 1, 0, 1, 1, 0);
        step(0, 1, 1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 1, 1, 0);
        step(0, 1, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 0);

        // reset mid-run at count 9, then a normal job
        step(0, 1, 15, 0, 15, 1, 0);
        for (int i = 14; i >= 9; i--)
            step(0, 0, 0, 0, WIDTH'(i), 1, 0);
        step(1, 1, 7, 1, 0, 0, 0);
        step(0, 1, 2, 0, 2, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        // full range, no wrap
        step(0, 1, 15, 0, 15, 1, 0);
        for (int i = 14; i >= 1; i--)
            step(0, 0, 0, 0, WIDTH'(i), 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        stim_done = 1'b1;
    end

    initial begin
        int budget;
        wait (stim_done);
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
